// File: rtl/afifo_pkg.sv
// Definitions shared by both sides of the async FIFO.
// Contents: skid-buffer state encoding and the Gray-code conversion helpers.
package afifo_pkg;

    localparam int GRAY_MAXW = 32;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Used by the read-side synchronizer path.
    function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] g);
        logic [GRAY_MAXW-1:0] b;
        b[GRAY_MAXW-1] = g[GRAY_MAXW-1];
        for (int i = GRAY_MAXW-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry skid buffer with head/tail registers; the head is always the older word.
// in_ready and out_valid decode from the state register only, so no ready/valid combinational loops.
//   state      | meaning
//   SKID_EMPTY | no words held
//   SKID_ONE   | head valid
//   SKID_TWO   | head and tail valid, upstream stalled
module skid_buf2
    import afifo_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic              wclk,
    input  logic              reset_L,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    input  logic              out_ready
);

    skid_state_t       r_state;
    skid_state_t       w_state_nxt;
    logic [DWIDTH-1:0] r_head;
    logic [DWIDTH-1:0] r_tail;
    logic              w_accept;
    logic              w_pop;
    logic              w_head_from_in;
    logic              w_head_from_tail;
    logic              w_tail_from_in;

    always_ff @(posedge wclk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= SKID_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge wclk or negedge reset_L) begin
        if (!reset_L) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_head_from_in) begin
                r_head <= in_data;
            end else if (w_head_from_tail) begin
                r_head <= r_tail;
            end
            if (w_tail_from_in) begin
                r_tail <= in_data;
            end
        end
    end

    always_comb begin
        in_ready         = (r_state != SKID_TWO);
        out_valid        = (r_state != SKID_EMPTY);
        w_accept         = in_valid && in_ready;
        w_pop            = out_valid && out_ready;
        w_state_nxt      = r_state;
        w_head_from_in   = 1'b0;
        w_head_from_tail = 1'b0;
        w_tail_from_in   = 1'b0;
        case (r_state)
            SKID_EMPTY: begin
                if (w_accept) begin
                    w_head_from_in = 1'b1;
                    w_state_nxt    = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (w_accept && w_pop) begin
                    w_head_from_in = 1'b1;
                end else if (w_accept) begin
                    w_tail_from_in = 1'b1;
                    w_state_nxt    = SKID_TWO;
                end else if (w_pop) begin
                    w_state_nxt    = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (w_pop) begin
                    w_head_from_tail = 1'b1;
                    w_state_nxt      = SKID_ONE;
                end
            end
            default: w_state_nxt = SKID_EMPTY;
        endcase
    end

    assign out_data = r_head;

endmodule

// File: rtl/wr_ingress.sv
// Write-side ingress of the async FIFO: skid-buffers producer words into the write controller,
// drives the RAM write port, and registers the Gray write pointer for the read-side synchronizer.
module wr_ingress
    import afifo_pkg::*;
#(
    parameter int PTRWIDTH = 4,
    parameter int DWIDTH   = 8
) (
    input  logic                wclk,
    input  logic                reset_L,
    input  logic                in_valid,
    input  logic [DWIDTH-1:0]   in_data,
    output logic                in_ready,
    output logic                push,
    input  logic                full,
    input  logic [PTRWIDTH:0]   wrptr_bin,
    output logic                wen,
    output logic [PTRWIDTH-1:0] waddr,
    output logic [DWIDTH-1:0]   wdata,
    output logic [PTRWIDTH:0]   wrptr_gray
);

    logic              w_out_ready;
    logic              w_push;
    logic [DWIDTH-1:0] w_head;
    logic [PTRWIDTH:0] r_wrptr_gray;

    assign w_out_ready = !full;

    skid_buf2 #(
        .DWIDTH (DWIDTH)
    ) u_skid (
        .wclk      (wclk),
        .reset_L   (reset_L),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (w_push),
        .out_data  (w_head),
        .out_ready (w_out_ready)
    );

    // Registered so the synchronizer only ever sees single-bit transitions.
    always_ff @(posedge wclk or negedge reset_L) begin
        if (!reset_L) begin
            r_wrptr_gray <= '0;
        end else begin
            r_wrptr_gray <= (PTRWIDTH+1)'(bin2gray(GRAY_MAXW'(wrptr_bin)));
        end
    end

    assign push       = w_push;
    assign wen        = w_push && !full;
    assign waddr      = wrptr_bin[PTRWIDTH-1:0];
    assign wdata      = w_head;
    assign wrptr_gray = r_wrptr_gray;

endmodule

// File: tb/tb_wr_ingress.sv
// Bench for wr_ingress: a small write-controller model drives full/wrptr_bin, and a negedge monitor
// scores every write against a queue of accepted words.
module tb_wr_ingress;

    localparam int PW = 4;
    localparam int DW = 8;

    logic          wclk = 1'b0;
    logic          reset_L;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          push;
    logic          full;
    logic [PW:0]   wrptr_bin;
    logic          wen;
    logic [PW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [PW:0]   wrptr_gray;

    wr_ingress #(.PTRWIDTH(PW), .DWIDTH(DW)) dut (
        .wclk       (wclk),
        .reset_L    (reset_L),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .push       (push),
        .full       (full),
        .wrptr_bin  (wrptr_bin),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .wrptr_gray (wrptr_gray)
    );

    always #5 wclk = ~wclk;

    int            n_cmp = 0;
    int            n_err = 0;
    int            total_wen = 0;
    int            occ;
    int            prod_pct;
    bit            prod_en, acc_flag, rd_auto, rd_pulse, force_full, hold_valid;
    logic [DW-1:0] hold_data;
    logic [PW-1:0] wen_cnt;
    logic [PW:0]   rdptr, prev_bin, last_gray;
    logic          ctl_full;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expire(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT at %0t", nm, $time);
    endtask

    task automatic tick();
        @(negedge wclk);
        #1;
    endtask

    function automatic logic [PW:0] gray_of(input logic [PW:0] b);
        return b ^ (b >> 1);
    endfunction

    // Write-controller model: full when write pointer is one lap ahead of read pointer.
    assign ctl_full = ((wrptr_bin ^ rdptr) == 5'b10000);
    assign full     = ctl_full || force_full;

    always @(posedge wclk or negedge reset_L) begin
        if (!reset_L) begin
            wrptr_bin <= '0;
            rdptr     <= '0;
            prev_bin  <= '0;
            occ       <= 0;
        end else begin
            prev_bin <= wrptr_bin;
            if (wen) wrptr_bin <= wrptr_bin + 1'b1;
            if (rd_pulse || (rd_auto && rdptr != wrptr_bin)) rdptr <= rdptr + 1'b1;
            occ <= occ + ((in_valid && in_ready) ? 1 : 0) - (wen ? 1 : 0);
        end
    end

    // Producer: advance to the next word only after the current one was taken.
    always @(posedge wclk) begin
        #1;
        if (acc_flag) begin
            in_data  = in_data + 8'd1;
            acc_flag = 1'b0;
        end
        in_valid = prod_en && ($urandom_range(0, 99) < prod_pct);
    end

    // Monitor / scoreboard.
    always @(negedge wclk) begin
        if (reset_L) begin
            if (wen) begin
                if (exp_q.size() == 0) expire("wen_without_accepted_word");
                else check("wdata", 32'(wdata), 32'(exp_q.pop_front()));
                check("waddr", 32'(waddr), 32'(wen_cnt));
                wen_cnt   = wen_cnt + 1'b1;
                total_wen = total_wen + 1;
            end
            check("wen_rule", 32'(wen), 32'(push && !full));
            check("in_ready_occ", 32'(in_ready), 32'(occ != 2));
            check("push_occ", 32'(push), 32'(occ != 0));
            check("gray_lag", 32'(wrptr_gray), 32'(gray_of(prev_bin)));
            if (wrptr_gray != last_gray)
                check("gray_1bit", 32'($countones(wrptr_gray ^ last_gray)), 32'd1);
            if (hold_valid && push) check("wdata_hold", 32'(wdata), 32'(hold_data));
            hold_valid = push && full;
            hold_data  = wdata;
            last_gray  = wrptr_gray;
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                acc_flag = 1'b1;
            end
        end
    end

    initial begin
        int t;
        reset_L    = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        prod_en    = 1'b1;
        prod_pct   = 100;
        force_full = 1'b0;
        rd_auto    = 1'b0;
        rd_pulse   = 1'b0;
        acc_flag   = 1'b0;
        hold_valid = 1'b0;
        hold_data  = '0;
        wen_cnt    = '0;
        last_gray  = '0;

        // Reset with in_valid high.
        repeat (3) tick();
        check("rst_in_valid_driven", 32'(in_valid), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_push", 32'(push), 32'd0);
        check("rst_wen", 32'(wen), 32'd0);
        check("rst_gray", 32'(wrptr_gray), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);
        @(posedge wclk); #1 reset_L = 1'b1;
        tick();
        tick();
        check("first_wen", 32'(wen), 32'd1);
        check("first_waddr", 32'(waddr), 32'd0);
        check("first_wdata", 32'(wdata), 32'h00);

        // Streaming into an idle read side until the skid buffer stalls.
        t = 0;
        while (in_ready && t < 60) begin tick(); t++; end
        if (in_ready) expire("stream_fill");
        check("stream_wen_count", 32'(total_wen), 32'd16);
        check("stream_held_head", 32'(wdata), 32'h10);
        check("stream_full", 32'(full), 32'd1);
        repeat (5) tick();
        check("full_no_more_wen", 32'(total_wen), 32'd16);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_head_stable", 32'(wdata), 32'h10);

        // Single read frees one slot.
        @(posedge wclk); #1 rd_pulse = 1'b1;
        @(posedge wclk); #1 rd_pulse = 1'b0;
        tick();
        check("rel_wen", 32'(wen), 32'd1);
        check("rel_waddr", 32'(waddr), 32'd0);
        check("rel_wdata", 32'(wdata), 32'h10);
        check("rel_in_ready_still_low", 32'(in_ready), 32'd0);
        tick();
        check("rel_gray", 32'(wrptr_gray), 32'b11000);
        check("rel_in_ready_back", 32'(in_ready), 32'd1);
        check("rel_wen_refull", 32'(wen), 32'd0);

        // Continuous reads: 40 more writes through the 31->0 wrap.
        rd_auto = 1'b1;
        t = 0;
        while (total_wen < 57 && t < 200) begin tick(); t++; end
        if (total_wen < 57) expire("gray_writes");

        // Random producer and random backpressure.
        prod_pct = 60;
        for (int i = 0; i < 300; i++) begin
            @(posedge wclk); #1 force_full = ($urandom_range(0, 99) < 30);
        end
        @(posedge wclk); #1 prod_en = 1'b0; force_full = 1'b0;
        t = 0;
        while ((push || exp_q.size() != 0) && t < 100) begin tick(); t++; end
        if (push) expire("random_drain");
        check("random_no_loss", 32'(exp_q.size()), 32'd0);

        // Reset while holding two words.
        prod_en    = 1'b1;
        prod_pct   = 100;
        force_full = 1'b1;
        t = 0;
        while (in_ready && t < 20) begin tick(); t++; end
        if (in_ready) expire("reset_fill");
        check("pre_reset_push", 32'(push), 32'd1);
        reset_L = 1'b0;
        exp_q.delete();
        acc_flag = 1'b0;
        prod_en  = 1'b0;
        #1;
        check("midrst_push", 32'(push), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_wen", 32'(wen), 32'd0);
        check("midrst_gray", 32'(wrptr_gray), 32'd0);
        wen_cnt    = '0;
        hold_valid = 1'b0;
        last_gray  = '0;
        in_data    = 8'hA5;
        force_full = 1'b0;
        repeat (2) @(posedge wclk);
        #1 reset_L = 1'b1;
        prod_en  = 1'b1;
        in_valid = 1'b1;
        t = 0;
        tick();
        while (!wen && t < 20) begin tick(); t++; end
        if (!wen) expire("post_reset_wen");
        check("post_rst_waddr", 32'(waddr), 32'd0);
        check("post_rst_wdata", 32'(wdata), 32'hA5);
        prod_en = 1'b0;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
